// File: rtl/aec_infix_to_postfix.sv
// Infix-to-postfix front stage: buffers one expression, then runs shunting-yard to a token stream.
// Define AEC_ERR_CHECK_EN to build the sticky malformed-input flag on err.
module aec_infix_to_postfix #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       tok_valid,
  input  logic       tok_ready,
  output logic       tok_is_op,
  output logic [3:0] tok_data,
  output logic       tok_last,
  output logic       busy,
  output logic       err
);

  localparam int unsigned LenW   = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW   = $clog2(MAX_LEN);
  localparam int unsigned SpW    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SpIdxW = $clog2(STACK_DEPTH);
  localparam logic [1:0]  OpLp   = 2'd3;
  localparam logic [7:0]  ChEq   = 8'h3D;

  typedef enum logic [1:0] {StIdle, StLoad, StConv, StFlush} state_e;

  function automatic logic is_num(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] num_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A);
  endfunction

  function automatic logic [1:0] op_code(input logic [7:0] c);
    return (c == 8'h2B) ? 2'd0 : (c == 8'h2D) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] prec(input logic [1:0] op);
    return (op == 2'd2) ? 2'd2 : 2'd1;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      char_buf_q [MAX_LEN];
  logic [1:0]      stack_q [STACK_DEPTH];
  logic [LenW-1:0] len_q, rd_ptr_q, last_tok_idx_q;
  logic            has_tok_q;
  logic [SpW-1:0]  sp_q, op_cnt_q;
  logic            tok_valid_q, tok_is_op_q, tok_last_q;
  logic [3:0]      tok_data_q;

  logic [7:0]        cur_char;
  logic              cur_is_num, cur_is_op, cur_is_lp, cur_is_rp;
  logic              accept, load_store, conv_done, conv_act, out_free;
  logic              stack_empty, stack_full, top_is_op, rest_tok;
  logic [SpIdxW-1:0] top_idx;
  logic [1:0]        top;
  logic              push, pop, emit, emit_op, emit_last, advance;
  logic [1:0]        push_val;
  logic [3:0]        emit_data;

  assign cur_char    = char_buf_q[rd_ptr_q[IdxW-1:0]];
  assign cur_is_num  = is_num(cur_char);
  assign cur_is_op   = is_op(cur_char);
  assign cur_is_lp   = (cur_char == 8'h28);
  assign cur_is_rp   = (cur_char == 8'h29);
  assign accept      = (state_q == StIdle) && ready;
  assign load_store  = (state_q == StLoad) && (ascii_in != ChEq) && (len_q < LenW'(MAX_LEN));
  assign conv_done   = (rd_ptr_q == len_q);
  assign out_free    = !tok_valid_q || tok_ready;
  assign conv_act    = (state_q == StConv) && !conv_done && out_free;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
  assign top_idx     = SpIdxW'(sp_q - 1'b1);
  assign top         = stack_q[top_idx];
  assign top_is_op   = !stack_empty && (top != OpLp);
  // Any operand/operator char still unread (including the current one) means more tokens follow.
  assign rest_tok    = has_tok_q && (rd_ptr_q <= last_tok_idx_q);

  always_comb begin
    push      = 1'b0;
    push_val  = 2'd0;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_op   = 1'b0;
    emit_data = 4'd0;
    emit_last = 1'b0;
    advance   = 1'b0;
    if (conv_act) begin
      if (cur_is_num) begin
        emit      = 1'b1;
        emit_data = num_val(cur_char);
        emit_last = (op_cnt_q == '0) && (rd_ptr_q == last_tok_idx_q);
        advance   = 1'b1;
      end else if (cur_is_lp) begin
        push     = 1'b1;
        push_val = OpLp;
        advance  = 1'b1;
      end else if (cur_is_rp && top_is_op) begin
        pop = 1'b1;
        emit = 1'b1;
      end else if (cur_is_rp) begin
        pop     = !stack_empty;
        advance = 1'b1;
      end else if (cur_is_op) begin
        if (top_is_op && (prec(top) >= prec(op_code(cur_char)))) begin
          pop  = 1'b1;
          emit = 1'b1;
        end else begin
          push     = 1'b1;
          push_val = op_code(cur_char);
          advance  = 1'b1;
        end
      end else begin
        advance = 1'b1;
      end
    end else if ((state_q == StFlush) && !stack_empty && out_free) begin
      pop  = 1'b1;
      emit = top_is_op;
    end
    if (pop && emit) begin
      emit_op   = 1'b1;
      emit_data = {2'b00, top};
      emit_last = (op_cnt_q == SpW'(1)) && !rest_tok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ready) state_d = (ascii_in == ChEq) ? StFlush : StLoad;
      StLoad:  if (ascii_in == ChEq) state_d = StConv;
      StConv:  if (conv_done) state_d = StFlush;
      StFlush: if (stack_empty && out_free) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (accept && (ascii_in != ChEq)) char_buf_q[0] <= ascii_in;
    else if (load_store)              char_buf_q[len_q[IdxW-1:0]] <= ascii_in;
    if (push && !stack_full) stack_q[sp_q[SpIdxW-1:0]] <= push_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q          <= '0;
      rd_ptr_q       <= '0;
      last_tok_idx_q <= '0;
      has_tok_q      <= 1'b0;
      sp_q           <= '0;
      op_cnt_q       <= '0;
      tok_valid_q    <= 1'b0;
      tok_is_op_q    <= 1'b0;
      tok_data_q     <= 4'd0;
      tok_last_q     <= 1'b0;
    end else begin
      if (accept) begin
        rd_ptr_q       <= '0;
        sp_q           <= '0;
        op_cnt_q       <= '0;
        len_q          <= (ascii_in == ChEq) ? '0 : LenW'(1);
        has_tok_q      <= is_num(ascii_in) || is_op(ascii_in);
        last_tok_idx_q <= '0;
      end else begin
        if (load_store) begin
          len_q <= len_q + 1'b1;
          if (is_num(ascii_in) || is_op(ascii_in)) begin
            has_tok_q      <= 1'b1;
            last_tok_idx_q <= len_q;
          end
        end
        if (advance) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !stack_full) begin
          sp_q <= sp_q + 1'b1;
          if (push_val != OpLp) op_cnt_q <= op_cnt_q + 1'b1;
        end else if (pop) begin
          sp_q <= sp_q - 1'b1;
          if (top_is_op) op_cnt_q <= op_cnt_q - 1'b1;
        end
      end
      if (emit) begin
        tok_valid_q <= 1'b1;
        tok_is_op_q <= emit_op;
        tok_data_q  <= emit_data;
        tok_last_q  <= emit_last;
      end else if (tok_ready) begin
        tok_valid_q <= 1'b0;
      end
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_is_op = tok_is_op_q;
  assign tok_data  = tok_data_q;
  assign tok_last  = tok_last_q;

`ifdef AEC_ERR_CHECK_EN
  logic err_q, err_set, last_tok_is_op_q;

  always_comb begin
    err_set = 1'b0;
    if ((state_q == StLoad) && (ascii_in != ChEq) && !load_store)               err_set = 1'b1;
    if (push && stack_full)                                                     err_set = 1'b1;
    if (conv_act && !cur_is_num && !cur_is_op && !cur_is_lp && !cur_is_rp)      err_set = 1'b1;
    if (conv_act && cur_is_rp && stack_empty)                                   err_set = 1'b1;
    if ((state_q == StFlush) && pop && !top_is_op)                              err_set = 1'b1;
    if ((state_q == StFlush) && (!has_tok_q || last_tok_is_op_q))               err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q            <= 1'b0;
      last_tok_is_op_q <= 1'b0;
    end else if (accept) begin
      err_q            <= 1'b0;
      last_tok_is_op_q <= is_op(ascii_in);
    end else begin
      if (err_set) err_q <= 1'b1;
      if (load_store && (is_num(ascii_in) || is_op(ascii_in))) last_tok_is_op_q <= is_op(ascii_in);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
